// File: rtl/fantasy_mode_ctrl.sv
// Frame-synchronous mode controller for the HDMI darkening datapath.
// Button toggles build a pending mode that commits only on vsync rise; auto mode drives blk with hysteresis.
module fantasy_mode_ctrl #(
  parameter int unsigned      SUM_W = 24,
  parameter logic [SUM_W-1:0] HI_TH = SUM_W'(24'd7000000),
  parameter logic [SUM_W-1:0] LO_TH = SUM_W'(24'd3000000),
  parameter int unsigned      HOLD  = 4
) (
  input  logic             vin_clk_i,
  input  logic             rst_n,
  input  logic             vs_i,
  input  logic             de_i,
  input  logic [2:0]       gray_i,
  input  logic             toggle_blk_i,
  input  logic             toggle_inv_i,
  input  logic             auto_toggle_i,
  input  logic             bypass_i,
  output logic [1:0]       mode_o,
  output logic [1:0]       mode_x_o,
  output logic [SUM_W-1:0] frame_sum_o,
  output logic             frame_sum_valid_o,
  output logic [3:0]       led_o
);

  typedef enum logic [1:0] {
    A_OFF    = 2'd0,
    A_DIRECT = 2'd1,
    A_BLK    = 2'd2
  } auto_state_e;

  localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};
  localparam logic [3:0]       HOLD_C  = 4'(HOLD);

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [2:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W-2){1'b0}}, b};
    sat_add = s[SUM_W] ? SUM_MAX : s[SUM_W-1:0];
  endfunction

  logic             vs_q;
  logic [1:0]       pending_q, pending_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       mode_x_q, mode_x_d;
  auto_state_e      auto_q, auto_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] frame_sum_q, frame_sum_d;
  logic             valid_q, valid_d;
  logic [3:0]       led_q, led_d;

  logic             vs_rise;
  logic             auto_en;
  logic             blk_next;
  logic [3:0]       cnt_inc;
  logic [SUM_W-1:0] acc_add;

  // Next-state: auto hysteresis, pending/commit, bypass mux, accumulator and LEDs.
  always_comb begin
    vs_rise  = vs_i & ~vs_q;
    auto_en  = (auto_q != A_OFF);
    cnt_inc  = cnt_q + 4'd1;
    auto_d   = auto_q;
    cnt_d    = cnt_q;
    blk_next = pending_q[1];

    // An auto toggle wins over the frame evaluation in the same cycle.
    if (auto_toggle_i) begin
      cnt_d = 4'd0;
      if (auto_q == A_OFF) begin
        auto_d = pending_q[1] ? A_BLK : A_DIRECT;
      end else begin
        auto_d = A_OFF;
      end
    end else if (valid_q) begin
      case (auto_q)
        A_DIRECT: begin
          if (frame_sum_q > HI_TH) begin
            if (cnt_inc == HOLD_C) begin
              blk_next = 1'b1;
              auto_d   = A_BLK;
              cnt_d    = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        A_BLK: begin
          if (frame_sum_q < LO_TH) begin
            if (cnt_inc == HOLD_C) begin
              blk_next = 1'b0;
              auto_d   = A_DIRECT;
              cnt_d    = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          cnt_d = 4'd0;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end

    pending_d[1] = (toggle_blk_i && !auto_en) ? ~pending_q[1] : blk_next;
    pending_d[0] = pending_q[0] ^ toggle_inv_i;

    // Commit sees same-cycle toggles because it loads pending_d, not pending_q.
    mode_d   = vs_rise ? pending_d : mode_q;
    mode_x_d = bypass_i ? 2'd0 : mode_q;

    acc_add = de_i ? sat_add(acc_q, gray_i) : acc_q;
    if (vs_rise) begin
      acc_d       = '0;
      frame_sum_d = acc_add;
      valid_d     = 1'b1;
    end else begin
      acc_d       = acc_add;
      frame_sum_d = frame_sum_q;
      valid_d     = 1'b0;
    end

    led_d = {mode_q[0], (pending_q != mode_q), auto_en, mode_q[1]};
  end

  // State registers; vs_q resets high so no edge is seen on the first frame.
  always_ff @(posedge vin_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b1;
      pending_q   <= 2'd2;
      mode_q      <= 2'd2;
      mode_x_q    <= 2'd2;
      auto_q      <= A_OFF;
      cnt_q       <= 4'd0;
      acc_q       <= '0;
      frame_sum_q <= '0;
      valid_q     <= 1'b0;
      led_q       <= 4'b0001;
    end else begin
      vs_q        <= vs_i;
      pending_q   <= pending_d;
      mode_q      <= mode_d;
      mode_x_q    <= mode_x_d;
      auto_q      <= auto_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
      valid_q     <= valid_d;
      led_q       <= led_d;
    end
  end

  assign mode_o            = mode_q;
  assign mode_x_o          = mode_x_q;
  assign frame_sum_o       = frame_sum_q;
  assign frame_sum_valid_o = valid_q;
  assign led_o             = led_q;

endmodule

// File: tb/tb_fantasy_mode_ctrl.sv
// Randomized bench for fantasy_mode_ctrl against a frame-level reference model.
// A second instance with an 8-bit accumulator covers saturation.
module tb_fantasy_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vs, de, tb_blk, tb_inv, tb_auto, bypass;
  logic [2:0] gray;

  logic [1:0]  mode1, modex1, mode2, modex2;
  logic [23:0] sum1;
  logic [7:0]  sum2;
  logic        valid1, valid2;
  logic [3:0]  led1, led2;

  int checks = 0;
  int errors = 0;

  // reference model state (frame level)
  logic [1:0] m_pending, m_mode;
  int         m_auto;  // 0 off, 1 direct, 2 blk
  int         m_cnt;

  always #5 clk = ~clk;

  fantasy_mode_ctrl #(.SUM_W(24), .HI_TH(24'd500), .LO_TH(24'd300), .HOLD(4)) dut (
    .vin_clk_i(clk), .rst_n(rst_n), .vs_i(vs), .de_i(de), .gray_i(gray),
    .toggle_blk_i(tb_blk), .toggle_inv_i(tb_inv), .auto_toggle_i(tb_auto), .bypass_i(bypass),
    .mode_o(mode1), .mode_x_o(modex1), .frame_sum_o(sum1), .frame_sum_valid_o(valid1), .led_o(led1));

  fantasy_mode_ctrl #(.SUM_W(8), .HI_TH(8'd200), .LO_TH(8'd100), .HOLD(4)) dut8 (
    .vin_clk_i(clk), .rst_n(rst_n), .vs_i(vs), .de_i(de), .gray_i(gray),
    .toggle_blk_i(tb_blk), .toggle_inv_i(tb_inv), .auto_toggle_i(tb_auto), .bypass_i(bypass),
    .mode_o(mode2), .mode_x_o(modex2), .frame_sum_o(sum2), .frame_sum_valid_o(valid2), .led_o(led2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_led();
    return {m_mode[0], (m_pending != m_mode), (m_auto != 0), m_mode[1]};
  endfunction

  task automatic model_reset();
    m_pending = 2'd2;
    m_mode    = 2'd2;
    m_auto    = 0;
    m_cnt     = 0;
  endtask

  task automatic model_toggle(input bit b, input bit i);
    if (b && m_auto == 0) m_pending[1] = ~m_pending[1];
    if (i) m_pending[0] = ~m_pending[0];
  endtask

  task automatic model_auto_toggle();
    if (m_auto == 0) m_auto = m_pending[1] ? 2 : 1;
    else m_auto = 0;
    m_cnt = 0;
  endtask

  task automatic model_eval(input int s);
    if (m_auto == 1) begin
      m_cnt = (s > 500) ? m_cnt + 1 : 0;
      if (m_cnt == 4) begin m_pending[1] = 1'b1; m_auto = 2; m_cnt = 0; end
    end else if (m_auto == 2) begin
      m_cnt = (s < 300) ? m_cnt + 1 : 0;
      if (m_cnt == 4) begin m_pending[1] = 1'b0; m_auto = 1; m_cnt = 0; end
    end
  endtask

  // One-cycle control pulse, then check mode held and LEDs updated.
  task automatic pulse(input bit b, input bit i, input bit a);
    tb_blk = b; tb_inv = i; tb_auto = a; de = 1'b0;
    model_toggle(b, i);
    if (a) model_auto_toggle();
    tick();
    tb_blk = 1'b0; tb_inv = 1'b0; tb_auto = 1'b0;
    tick();
    checks++;
    if (mode1 !== m_mode) begin errors++; $display("FAIL pulse_mode_hold got %0d want %0d", mode1, m_mode); end
    checks++;
    if (led1 !== exp_led()) begin errors++; $display("FAIL pulse_led got %b want %b", led1, exp_led()); end
  endtask

  // One video frame; gray g (<0 random); toggles optionally mid-frame and on the vsync rise cycle.
  task automatic run_frame(input int npix, input int g, input bit rise_inv, input bit rise_blk,
                           input bit edge_pix, input bit mid_blk, input bit mid_inv);
    int total;
    int e2;
    logic [2:0] gv;
    total = 0;
    vs = 1'b0; de = 1'b0;
    tick();
    for (int i = 0; i < npix; i++) begin
      gv = (g < 0) ? 3'($urandom_range(0, 7)) : 3'(g);
      de = 1'b1; gray = gv; total += int'(gv);
      if (i == npix / 2) begin tb_blk = mid_blk; tb_inv = mid_inv; model_toggle(mid_blk, mid_inv); end
      if (i == npix - 1) begin
        checks++;
        if (mode1 !== m_mode) begin errors++; $display("FAIL mode_midframe got %0d want %0d", mode1, m_mode); end
        if (edge_pix) begin
          vs = 1'b1; tb_blk = rise_blk; tb_inv = rise_inv; model_toggle(rise_blk, rise_inv);
        end
      end
      tick();
      tb_blk = 1'b0; tb_inv = 1'b0;
      if (i != npix - 1 && $urandom_range(0, 3) == 0) begin de = 1'b0; tick(); end
    end
    if (!edge_pix) begin
      de = 1'b0; vs = 1'b1; tb_blk = rise_blk; tb_inv = rise_inv; model_toggle(rise_blk, rise_inv);
      tick();
    end
    de = 1'b0; tb_blk = 1'b0; tb_inv = 1'b0;
    m_mode = m_pending;
    e2 = (total > 255) ? 255 : total;
    checks++;
    if (valid1 !== 1'b1 || sum1 !== 24'(total)) begin
      errors++; $display("FAIL frame_sum got %0d/%b want %0d/1", sum1, valid1, total);
    end
    checks++;
    if (valid2 !== 1'b1 || sum2 !== 8'(e2)) begin
      errors++; $display("FAIL frame_sum_sat got %0d/%b want %0d/1", sum2, valid2, e2);
    end
    checks++;
    if (mode1 !== m_mode) begin errors++; $display("FAIL mode_commit got %0d want %0d", mode1, m_mode); end
    tick();
    checks++;
    if (valid1 !== 1'b0) begin errors++; $display("FAIL valid_single got %b want 0", valid1); end
    checks++;
    if (modex1 !== (bypass ? 2'd0 : m_mode)) begin errors++; $display("FAIL mode_x got %0d want %0d", modex1, m_mode); end
    model_eval(total);
    tick();
    checks++;
    if (led1 !== exp_led()) begin errors++; $display("FAIL frame_led got %b want %b", led1, exp_led()); end
  endtask

  task automatic set_mode(input logic [1:0] target);
    if (m_auto != 0) pulse(1'b0, 1'b0, 1'b1);
    if (m_pending[1] != target[1]) pulse(1'b1, 1'b0, 1'b0);
    if (m_pending[0] != target[0]) pulse(1'b0, 1'b1, 1'b0);
    run_frame(8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vs = 1'b1; de = 1'b0; gray = 3'd0;
    tb_blk = 1'b0; tb_inv = 1'b0; tb_auto = 1'b0; bypass = 1'b0;
    model_reset();
    #23;
    checks++;
    if (mode1 !== 2'd2 || modex1 !== 2'd2 || sum1 !== 24'd0 || valid1 !== 1'b0 || led1 !== 4'b0001) begin
      errors++; $display("FAIL reset_values mode %0d mode_x %0d sum %0d valid %b led %b", mode1, modex1, sum1, valid1, led1);
    end
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (mode1 !== 2'd2 || modex1 !== 2'd2 || led1 !== 4'b0001 || valid1 !== 1'b0) begin
      errors++; $display("FAIL post_reset mode %0d mode_x %0d led %b valid %b want 2 2 0001 0", mode1, modex1, led1, valid1);
    end
  endtask

  task automatic test_toggle_commit();
    vs = 1'b0; tick();
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (mode1 !== 2'd2 || led1[2] !== 1'b1) begin
      errors++; $display("FAIL blk_pending mode %0d led2 %b want 2 1", mode1, led1[2]);
    end
    run_frame(20, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mode1 !== 2'd0 || led1[2] !== 1'b0) begin
      errors++; $display("FAIL blk_commit mode %0d led2 %b want 0 0", mode1, led1[2]);
    end
  endtask

  task automatic test_simultaneous();
    pulse(1'b1, 1'b1, 1'b0);
    run_frame(10, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mode1 !== 2'd3 || led1 !== 4'b1001) begin
      errors++; $display("FAIL both_toggles mode %0d led %b want 3 1001", mode1, led1);
    end
  endtask

  task automatic test_bypass();
    set_mode(2'd2);
    vs = 1'b0; tick();
    bypass = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (modex1 !== 2'd0 || mode1 !== 2'd2) begin
        errors++; $display("FAIL bypass_on mode_x %0d mode %0d want 0 2", modex1, mode1);
      end
    end
    bypass = 1'b0;
    tick();
    checks++;
    if (modex1 !== 2'd2) begin errors++; $display("FAIL bypass_off mode_x %0d want 2", modex1); end
  endtask

  task automatic test_saturation();
    run_frame(100, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(40, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 14; f++) begin
      if ($urandom_range(0, 2) == 0) pulse(1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 2) == 0) pulse(1'b0, 1'b1, 1'b0);
      if ($urandom_range(0, 4) == 0) pulse(1'b0, 1'b0, 1'b1);
      run_frame($urandom_range(4, 150), -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_auto();
    int gs[7];
    gs = '{7, 7, 4, 7, 7, 7, 7};
    set_mode(2'd0);
    pulse(1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 7; f++) begin
      pulse(1'b1, 1'b0, 1'b0);
      run_frame(100, gs[f], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (led1[2] !== ((f == 6) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL auto_rise_frame%0d led2 %b", f, led1[2]);
      end
    end
    run_frame(100, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mode1 !== 2'd2) begin errors++; $display("FAIL auto_blk_commit mode %0d want 2", mode1); end
    for (int f = 0; f < 4; f++) run_frame(100, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mode1 !== 2'd1) begin errors++; $display("FAIL auto_clear_commit mode %0d want 1", mode1); end
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    run_frame(12, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    vs = 1'b0;
    for (int k = 0; k < 6; k++) begin de = 1'b1; gray = 3'd6; tick(); end
    de = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (mode1 !== 2'd2 || sum1 !== 24'd0 || valid1 !== 1'b0 || led1 !== 4'b0001) begin
      errors++; $display("FAIL async_reset mode %0d sum %0d valid %b led %b", mode1, sum1, valid1, led1);
    end
    @(negedge clk); rst_n = 1'b1;
    run_frame(30, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_toggle_commit();
    test_simultaneous();
    test_bypass();
    test_saturation();
    test_random();
    test_auto();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fantasy_mode_ctrl.md
Name: fantasy_mode_ctrl

Overview:
- Frame-synchronous mode controller for the HDMI darkening datapath.
- Turns button events into a pending output mode and commits it only at the vsync rising edge, so the per-pixel invert selection never changes mid-frame.
- Accumulates per-frame gray statistics and, when auto mode is enabled, drives the block-darkening bit with hysteresis over several frames.
- Drives the status LEDs.

Parameters:
- SUM_W, 24, width of the frame gray accumulator; saturates, no wrap.
- HI_TH, 24'd7000000, frame sum strictly above this counts as a bright frame.
- LO_TH, 24'd3000000, frame sum strictly below this counts as a dark frame; LO_TH < HI_TH required.
- HOLD, 4, consecutive qualifying frames needed before auto changes the blk bit; range 1..15.

Ports:
- vin_clk_i  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- vs_i  in  1  registered vsync from the input stage.
- de_i  in  1  registered data enable.
- gray_i  in  3  per-pixel gray level, aligned with de_i.
- toggle_blk_i  in  1  single-cycle press pulse; flips mode bit1 (blk).
- toggle_inv_i  in  1  single-cycle press pulse; flips mode bit0 (inv).
- auto_toggle_i  in  1  single-cycle pulse; toggles auto enable.
- bypass_i  in  1  level input; forces DIRECT while high.
- mode_o  out  2  committed mode: 0 DIRECT, 1 INV, 2 BLK_DARK, 3 BLK_LIGHT.
- mode_x_o  out  2  effective mode fed to the datapath (mode_o, or DIRECT while bypassed).
- frame_sum_o  out  SUM_W  gray sum of the last complete frame.
- frame_sum_valid_o  out  1  one-cycle pulse when frame_sum_o updates.
- led_o  out  4  status LEDs.

Behaviour:
- Reset is asynchronous. Reset values:
  - mode_o = 2, pending = 2, mode_x_o = 2.
  - auto_en = 0, auto FSM = A_OFF, hysteresis count = 0.
  - accumulator = 0, frame_sum_o = 0, frame_sum_valid_o = 0.
  - led_o = 4'b0001.
  - The internal vs delay register resets to 1, so the first frame after reset produces no spurious edge.
- Reset asserted mid-frame aborts the accumulation. The first frame_sum_valid_o after reset reports a partial sum; consumers treat it as valid.
- Frame edge: vs_rise = vs_i & ~vs_q, with vs_q a one-cycle delay of vs_i.
- Pending mode, updated every cycle:
  - toggle_blk_i XORs pending[1]; toggle_inv_i XORs pending[0].
  - Simultaneous pulses apply both flips (DIRECT to BLK_LIGHT).
  - While auto_en = 1, toggle_blk_i is ignored and pending[1] is owned by the auto FSM.
- Commit: on the cycle vs_rise = 1, mode_o loads the pending value, including any toggle arriving in that same cycle. mode_o is visible the next cycle. mode_o never changes on any other cycle.
- Bypass: mode_x_o is registered as bypass_i ? 0 : mode_o, giving 1-cycle latency. Bypass is not frame-synced and does not alter pending or mode_o.
- Accumulator:
  - When de_i = 1, adds gray_i, saturating at 2^SUM_W-1.
  - On vs_rise: frame_sum_o <= accumulator value including the current cycle, frame_sum_valid_o pulses for 1 cycle, and the accumulator clears to 0.
  - de_i is low during vsync in normal video; if de_i is high on vs_rise, that pixel is counted in the closing frame.
- Auto FSM; states A_OFF, A_DIRECT, A_BLK; evaluated on the cycle frame_sum_valid_o = 1, using frame_sum_o.
  - auto_toggle_i while A_OFF: enter A_BLK if pending[1] = 1, else A_DIRECT; count = 0.
  - auto_toggle_i in any other state: go to A_OFF and leave pending[1] unchanged.
  - A_DIRECT: sum > HI_TH increments count, otherwise count = 0. When count reaches HOLD: set pending[1] = 1, go to A_BLK, count = 0.
  - A_BLK: sum < LO_TH increments count, otherwise count = 0. When count reaches HOLD: clear pending[1], go to A_DIRECT, count = 0.
  - The auto-driven pending change commits at the next vs_rise, so the effect lands one frame after the deciding frame.
  - auto_en is 1 in any state other than A_OFF.
- LEDs (registered, updated each cycle):
  - led_o[3] = mode_o[0]; led_o[0] = mode_o[1].
  - led_o[1] = auto_en.
  - led_o[2] = (pending != mode_o), meaning a change is awaiting commit.

Test Plan:
- Reset, then toggle_blk_i pulse mid-frame: mode_o stays 2 until vs_rise, becomes 0 the cycle after; led_o[2] = 1 in between, 0 after.
- toggle_blk_i and toggle_inv_i in the same cycle with mode 0: pending = 3; after the next vs_rise, mode_o = 3 and led_o = 4'b1001.
- bypass_i high for 10 cycles mid-frame with mode 2: mode_x_o = 0 one cycle after assertion, back to 2 one cycle after release; mode_o stays 2 throughout.
- Frame of 100 pixels with gray = 7, then vs_rise: frame_sum_o = 700, single valid pulse. With SUM_W = 8, the same frame saturates to 255.
- Auto on at mode 0, HOLD = 4, HI_TH = 500, sums 700/700/400/700×4: pending[1] sets only after the 7th frame; mode_o = 2 after the following vs_rise. toggle_blk_i is ignored throughout.
- Auto in A_BLK, LO_TH = 300, four frames with sum 100, and a toggle arriving on the vs_rise cycle: pending[1] clears, and the same-cycle toggle is included in that commit.
